// File: rtl/gps_multitap_correlator.sv
// Multi-tap GPS/Galileo code correlator: 1-bit IF sample mixed with a quadrature LO and per-tap delayed code,
// integrated over 1..16 epochs per tap and dumped to a CPU-read serial register with ready/overrun status.
module gps_multitap_correlator #(
  parameter int NTAPS      = 3,
  parameter int INTEG_BITS = 18,
  parameter int DLY_DEPTH  = 16,
  parameter int DLY_BITS   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample,
  input  logic        lo_wr,
  input  logic        tap_wr,
  input  logic        intg_wr,
  input  logic [31:0] wdata,
  input  logic        code_in,
  input  logic        sub_strobe,
  input  logic        epoch,
  input  logic        shift,
  input  logic        rd_ack,
  output logic        sout,
  output logic        dump_rdy,
  output logic        overrun
);
  localparam int SER_W = 2 * NTAPS * INTEG_BITS;
  localparam logic [INTEG_BITS-1:0] PLUS1  = INTEG_BITS'(1);
  localparam logic [INTEG_BITS-1:0] MINUS1 = '1;

  logic [31:0]           lo_rate, lo_phase;
  logic                  lo_i, lo_q;
  logic [DLY_DEPTH-1:0]  dl;
  logic [DLY_BITS-1:0]   tap_off [NTAPS];
  logic [NTAPS-1:0]      di, dq;
  logic                  mix_vld, epoch_d;
  logic [3:0]            n_epochs_m1, ecnt;
  logic                  dump;
  logic [INTEG_BITS-1:0] acc_i [NTAPS];
  logic [INTEG_BITS-1:0] acc_q [NTAPS];
  logic [SER_W-1:0]      snap, ser;

  assign sout = ser[SER_W-1];

  always_comb begin
    lo_i = ~lo_phase[31];
    lo_q = lo_phase[31] ^ lo_phase[30];
    // A length write restarts the integration, so it suppresses any dump that would coincide.
    dump = epoch_d && !intg_wr && (ecnt == n_epochs_m1);
    snap = '0;
    for (int k = 0; k < NTAPS; k++) begin
      snap[SER_W-1-(2*k)*INTEG_BITS -: INTEG_BITS]   = acc_i[k];
      snap[SER_W-1-(2*k+1)*INTEG_BITS -: INTEG_BITS] = acc_q[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lo_rate  <= '0;
      lo_phase <= '0;
      dl       <= '0;
      di       <= '0;
      dq       <= '0;
      mix_vld  <= 1'b0;
      epoch_d  <= 1'b0;
      for (int k = 0; k < NTAPS; k++) tap_off[k] <= DLY_BITS'(2 * k);
    end else begin
      if (lo_wr) lo_rate <= wdata;
      lo_phase <= lo_phase + lo_rate;
      if (sub_strobe) dl <= {dl[DLY_DEPTH-2:0], code_in};
      for (int k = 0; k < NTAPS; k++) begin
        if (tap_wr && wdata[18:16] == 3'(k)) tap_off[k] <= wdata[DLY_BITS-1:0];
        di[k] <= sample ^ dl[tap_off[k]] ^ lo_i;
        dq[k] <= sample ^ dl[tap_off[k]] ^ lo_q;
      end
      // Mixer output is meaningless in the first cycle out of reset.
      mix_vld <= 1'b1;
      epoch_d <= epoch;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      n_epochs_m1 <= '0;
      ecnt        <= '0;
      ser         <= '0;
      dump_rdy    <= 1'b0;
      overrun     <= 1'b0;
      for (int k = 0; k < NTAPS; k++) begin
        acc_i[k] <= '0;
        acc_q[k] <= '0;
      end
    end else begin
      if (intg_wr) begin
        n_epochs_m1 <= wdata[3:0];
        ecnt        <= '0;
      end else if (epoch_d) begin
        ecnt <= dump ? 4'd0 : ecnt + 4'd1;
      end

      for (int k = 0; k < NTAPS; k++) begin
        if (intg_wr) begin
          acc_i[k] <= '0;
          acc_q[k] <= '0;
        end else if (mix_vld) begin
          // On a dump the current cycle's chip seeds the next integration.
          acc_i[k] <= (dump ? '0 : acc_i[k]) + (di[k] ? MINUS1 : PLUS1);
          acc_q[k] <= (dump ? '0 : acc_q[k]) + (dq[k] ? MINUS1 : PLUS1);
        end
      end

      if (dump) ser <= snap;
      else if (shift) ser <= {ser[SER_W-2:0], 1'b0};

      if (dump) begin
        dump_rdy <= 1'b1;
        if (dump_rdy && !rd_ack) overrun <= 1'b1;
      end else if (rd_ack) begin
        dump_rdy <= 1'b0;
        overrun  <= 1'b0;
      end
    end
  end
endmodule
